// File: rtl/cv32e40p_tb_status_periph.sv
// Test-status responder on the core's OBI data bus: buffers firmware characters in a
// small FIFO and publishes pass/fail/exit only once every buffered character has left.
module cv32e40p_tb_status_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] PASS_CODE  = 32'd123456789,
  parameter logic [31:0] FAIL_CODE  = 32'd1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_data_o,
  input  logic        stdout_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   cycle_q;
  logic          rvalid_q;
  logic [31:0]   rdata_q;
  logic          verdict_set_q, verdict_pass_q, exit_set_q;
  logic [31:0]   exit_code_q;
  logic          passed_q, failed_q, exit_valid_q;
  logic [31:0]   exit_value_q;

  logic          in_window;
  logic [1:0]    reg_sel;
  logic          stdout_wr, push, pop, status_wr, exit_wr;
  logic          verdict_hit, exit_hit, verdict_pass_d;
  logic [31:0]   exit_code_d, read_value;
  logic          unused_bits;

  assign unused_bits = ^{be_i[3:1], addr_i[1:0]};

  assign in_window = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = addr_i[3:2];

  // A STDOUT write is held off (gnt_o low) while the FIFO is full, even if the
  // consumer pops in the same cycle; every other access is granted immediately.
  assign stdout_wr = req_i && we_i && in_window && (reg_sel == 2'd0);
  assign gnt_o     = req_i && !(stdout_wr && (count_q == FULL_COUNT));

  // stdout stream: a character moves only in a cycle where valid and ready are both high.
  assign push    = gnt_o && stdout_wr && be_i[0];
  assign pop     = stdout_valid_o && stdout_ready_i;
  assign count_d = count_q + CW'(push) - CW'(pop);

  assign status_wr      = gnt_o && we_i && in_window && (reg_sel == 2'd1);
  assign exit_wr        = gnt_o && we_i && in_window && (reg_sel == 2'd2);
  assign verdict_hit    = status_wr && !verdict_set_q &&
                          ((wdata_i == PASS_CODE) || (wdata_i == FAIL_CODE));
  assign exit_hit       = exit_wr && !exit_set_q;
  assign verdict_pass_d = verdict_hit ? (wdata_i == PASS_CODE) : verdict_pass_q;
  assign exit_code_d    = exit_hit ? wdata_i : exit_code_q;
  assign read_value     = (!we_i && in_window && (reg_sel == 2'd3)) ? cycle_q : 32'h0;

  assign stdout_valid_o = (count_q != '0);
  assign stdout_data_o  = stdout_valid_o ? fifo_mem[rptr_q] : 8'h00;
  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_q] <= wdata_i[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      cycle_q        <= 32'h0;
      rvalid_q       <= 1'b0;
      rdata_q        <= 32'h0;
      verdict_set_q  <= 1'b0;
      verdict_pass_q <= 1'b0;
      exit_set_q     <= 1'b0;
      exit_code_q    <= 32'h0;
      passed_q       <= 1'b0;
      failed_q       <= 1'b0;
      exit_valid_q   <= 1'b0;
      exit_value_q   <= 32'h0;
    end else begin
      cycle_q  <= cycle_q + 32'd1;
      rvalid_q <= gnt_o;
      rdata_q  <= gnt_o ? read_value : 32'h0;
      count_q  <= count_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (verdict_hit) begin
        verdict_set_q  <= 1'b1;
        verdict_pass_q <= verdict_pass_d;
      end
      if (exit_hit) begin
        exit_set_q  <= 1'b1;
        exit_code_q <= wdata_i;
      end
      // Publish only when the FIFO will be empty next cycle; the pending values never
      // change once latched, so re-publishing keeps the outputs sticky.
      if (count_d == '0) begin
        if (verdict_set_q || verdict_hit) begin
          passed_q <= verdict_pass_d;
          failed_q <= !verdict_pass_d;
        end
        if (exit_set_q || exit_hit) begin
          exit_valid_q <= 1'b1;
          exit_value_q <= exit_code_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_tb_status_periph.sv
// Bench for cv32e40p_tb_status_periph: directed steps plus a random phase, with a
// negedge monitor holding a queue/flag model of the status window.
module tb_cv32e40p_tb_status_periph;

  localparam logic [31:0] BASE     = 32'h1000_0000;
  localparam logic [31:0] PASS_VAL = 32'd123456789;
  localparam logic [31:0] FAIL_VAL = 32'd1;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] A_STDOUT = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_EXIT   = BASE + 32'h8;
  localparam logic [31:0] A_CYCLE  = BASE + 32'hC;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = 32'h0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = 4'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        stdout_valid_o;
  logic [7:0]  stdout_data_o;
  logic        stdout_ready_i = 1'b0;
  logic        tests_passed_o, tests_failed_o, exit_valid_o;
  logic [31:0] exit_value_o;

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;  // 0 = low, 1 = high, 2 = random each cycle
  bit cyc_ok = 1'b1;   // monitor may compare CYCLE reads with its own cycle count

  // Reference model state, owned by the monitor.
  logic [7:0]  exp_q[$];
  bit          m_vset, m_vpass, m_eset, m_pv, m_pe;
  logic [31:0] m_ecode, m_cycle;
  bit          p_gnt, p_cyc;
  logic [31:0] p_rdata;
  bit          mon_in_win, mon_stdout_wr, mon_gnt;
  logic [1:0]  mon_sel;

  logic [31:0] dummy, ra, rb, r0, r1, r2, tmp_addr;

  cv32e40p_tb_status_periph dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .addr_i         (addr_i),
    .we_i           (we_i),
    .be_i           (be_i),
    .wdata_i        (wdata_i),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .stdout_valid_o (stdout_valid_o),
    .stdout_data_o  (stdout_data_o),
    .stdout_ready_i (stdout_ready_i),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o)
  );

  // Clock and reset-independent drivers
  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #2;
    case (ready_mode)
      0:       stdout_ready_i = 1'b0;
      1:       stdout_ready_i = 1'b1;
      default: stdout_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard / reference model: evaluated mid-cycle, then advanced across the next edge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      m_vset = 0; m_vpass = 0; m_eset = 0; m_pv = 0; m_pe = 0;
      m_ecode = 32'h0; m_cycle = 32'h0;
      p_gnt = 0; p_cyc = 0; p_rdata = 32'h0;
    end else begin
      if (m_vset && exp_q.size() == 0) m_pv = 1;
      if (m_eset && exp_q.size() == 0) m_pe = 1;
      check("stdout_valid", stdout_valid_o, exp_q.size() != 0);
      check("stdout_data", stdout_data_o, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
      check("passed", tests_passed_o, m_pv && m_vpass);
      check("failed", tests_failed_o, m_pv && !m_vpass);
      check("exit_valid", exit_valid_o, m_pe);
      check("exit_value", exit_value_o, m_pe ? m_ecode : 32'h0);
      check("rvalid", rvalid_o, p_gnt);
      if (cyc_ok || !p_cyc) check("rdata", rdata_o, p_rdata);
      mon_in_win    = (addr_i[31:4] == BASE[31:4]);
      mon_sel       = addr_i[3:2];
      mon_stdout_wr = req_i && we_i && mon_in_win && (mon_sel == 2'd0);
      mon_gnt       = req_i && !(mon_stdout_wr && exp_q.size() == DEPTH);
      check("gnt", gnt_o, mon_gnt);
      p_gnt = mon_gnt; p_cyc = 0; p_rdata = 32'h0;
      if (mon_gnt && !we_i && mon_in_win && mon_sel == 2'd3) begin
        p_rdata = m_cycle;
        p_cyc   = 1;
      end
      if (exp_q.size() != 0 && stdout_ready_i) void'(exp_q.pop_front());
      if (mon_gnt && we_i && mon_in_win) begin
        case (mon_sel)
          2'd0: if (be_i[0]) exp_q.push_back(wdata_i[7:0]);
          2'd1: if (!m_vset && (wdata_i == PASS_VAL || wdata_i == FAIL_VAL)) begin
                  m_vset  = 1;
                  m_vpass = (wdata_i == PASS_VAL);
                end
          2'd2: if (!m_eset) begin
                  m_eset  = 1;
                  m_ecode = wdata_i;
                end
          default: ;
        endcase
      end
      m_cycle = m_cycle + 32'd1;
    end
  end

  // Driver: called and returns at posedge+1; back-to-back calls give back-to-back requests.
  task automatic obi(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, output logic [31:0] rd);
    int n = 0;
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
    @(negedge clk_i);
    while (!gnt_o && n < 32) begin
      @(negedge clk_i);
      n++;
    end
    if (!gnt_o) begin
      check("gnt_timeout", gnt_o, 1'b1);
      req_i = 1'b0;
      rd = 32'h0;
      @(posedge clk_i); #1;
      return;
    end
    @(posedge clk_i); #1;
    rd = rdata_o;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] rd;
    obi(1'b1, addr, be, wd, rd);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("drain_valid", stdout_valid_o, 1'b0);
  endtask

  initial begin
    idle(3);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_rvalid", rvalid_o, 1'b0);
    check("rst_stdout_valid", stdout_valid_o, 1'b0);
    check("rst_exit_value", exit_value_o, 32'h0);
    @(posedge clk_i); #1;

    // "Hi" with the consumer always ready
    ready_mode = 1;
    idle(1);
    wr(A_STDOUT, 4'h1, 32'h48);
    wr(A_STDOUT, 4'h1, 32'h69);
    idle(3);

    // Nine characters into an eight-entry FIFO with the consumer stalled
    ready_mode = 0;
    idle(2);
    for (int i = 0; i < DEPTH; i++) wr(A_STDOUT, 4'hF, 32'($urandom_range(32, 126)));
    fork
      wr(A_STDOUT, 4'h1, 32'h39);
      begin
        repeat (3) begin
          @(negedge clk_i);
          check("full_stall", gnt_o, 1'b0);
        end
        @(posedge clk_i); #1;
        ready_mode = 1;
        @(negedge clk_i);
        check("full_pop_refused", gnt_o, 1'b0);
        @(posedge clk_i); #1;
        ready_mode = 0;
      end
    join
    drain();

    // Random traffic against the model
    ready_mode = 2;
    repeat (60) begin
      case ($urandom_range(0, 5))
        0, 1: wr(A_STDOUT, 4'($urandom_range(0, 15)), $urandom);
        2:    obi(1'b0, BASE + {28'h0, 2'($urandom_range(0, 3)), 2'b00}, 4'hF, 32'h0, dummy);
        3: begin
          tmp_addr = $urandom;
          if (tmp_addr[31:4] == BASE[31:4]) tmp_addr[31] = ~tmp_addr[31];
          obi(1'($urandom_range(0, 1)), tmp_addr, 4'hF, $urandom, dummy);
        end
        4:    wr(A_STATUS, 4'hF, 32'($urandom_range(2, 1000)));
        default: idle($urandom_range(0, 2));
      endcase
    end
    drain();

    // Exit held back behind three buffered characters
    ready_mode = 0;
    idle(2);
    for (int i = 0; i < 3; i++) wr(A_STDOUT, 4'h1, 32'h41 + 32'(i));
    wr(A_EXIT, 4'h0, 32'h0);
    idle(3);
    check("exit_held", exit_valid_o, 1'b0);
    drain();
    @(negedge clk_i);
    check("exit_after_drain", exit_valid_o, 1'b1);
    check("exit_code_zero", exit_value_o, 32'h0);
    @(posedge clk_i); #1;

    // First verdict wins
    wr(A_STATUS, 4'h0, PASS_VAL);
    wr(A_STATUS, 4'hF, FAIL_VAL);
    idle(2);
    check("passed_sticky", tests_passed_o, 1'b1);
    check("failed_low", tests_failed_o, 1'b0);

    // Asynchronous reset with characters queued and a published verdict
    ready_mode = 0;
    idle(2);
    for (int i = 0; i < 4; i++) wr(A_STDOUT, 4'h1, 32'($urandom_range(0, 255)));
    idle(1);
    rst_i = 1'b1;
    #1;
    check("arst_rvalid", rvalid_o, 1'b0);
    check("arst_rdata", rdata_o, 32'h0);
    check("arst_stdout_valid", stdout_valid_o, 1'b0);
    check("arst_stdout_data", stdout_data_o, 8'h00);
    check("arst_passed", tests_passed_o, 1'b0);
    check("arst_failed", tests_failed_o, 1'b0);
    check("arst_exit_valid", exit_valid_o, 1'b0);
    check("arst_exit_value", exit_value_o, 32'h0);
    idle(2);
    rst_i = 1'b0;

    // Exit latches the first value only
    wr(A_EXIT, 4'hF, 32'd5);
    wr(A_EXIT, 4'hF, 32'd7);
    idle(2);
    check("exit_first_valid", exit_valid_o, 1'b1);
    check("exit_first_value", exit_value_o, 32'd5);

    // CYCLE reads ten grant cycles apart
    obi(1'b0, A_CYCLE, 4'hF, 32'h0, ra);
    repeat (9) @(posedge clk_i);
    #1;
    obi(1'b0, A_CYCLE, 4'hF, 32'h0, rb);
    check("cycle_delta", rb - ra, 32'd10);

    // Counter wrap
    cyc_ok = 1'b0;
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    obi(1'b0, A_CYCLE, 4'hF, 32'h0, r0);
    obi(1'b0, A_CYCLE, 4'hF, 32'h0, r1);
    obi(1'b0, A_CYCLE, 4'hF, 32'h0, r2);
    check("wrap_m2", r0, 32'hFFFF_FFFE);
    check("wrap_m1", r1, 32'hFFFF_FFFF);
    check("wrap_zero", r2, 32'h0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
